fp_adder: RTL and testbench

//   IEEE-754 single-precision (binary32) adder/subtractor; operand signs determine add vs subtract.

---
 rtl/fp32_pkg.sv | 14 +
 rtl/fp_lzc24.sv | 12 +
 rtl/fp_adder.sv | 82 ++++++++
 tb/tb_fp_adder.sv | 72 +++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 format constants and the packed fp32 field layout
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: combinational leading-zero count of a 24-bit significand
// ports: d (24-bit value), cnt (zeros above the leading one, 24 when d is all zero)
module fp_lzc24 (
  input  logic [23:0] d,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++)
      if (d[i]) cnt = 5'(23 - i);
  end
endmodule

// File: rtl/fp_adder.sv
// fp_adder: binary32 add/subtract with round-to-nearest-even and one output register
// ports: clk, rst_n (async active-low), A/B operands, Sum registered result,
//        overflow (finite inputs rounded to Inf), underflow (tiny and inexact)
module fp_adder
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Sum,
  output logic        overflow,
  output logic        underflow
);
  fp32_t a, b, big, sml;
  logic a_nan, b_nan, a_inf, b_inf, swap, sub, lost, inexact, rup, ovf, zero;
  logic [7:0] eb_eff, es_eff, d;
  logic [26:0] sml_ext, sml_sh, aligned, norm;
  logic [27:0] big_ext, raw;
  logic [4:0] lz;
  logic [8:0] e, lim, sh, en, ef;
  logic [31:0] rnd, n_sum;
  logic n_ovf, n_unf;
  assign a = A;
  assign b = B;
  assign a_nan = a.exp == EXP_MAX && a.frac != '0;
  assign b_nan = b.exp == EXP_MAX && b.frac != '0;
  assign a_inf = a.exp == EXP_MAX && a.frac == '0;
  assign b_inf = b.exp == EXP_MAX && b.frac == '0;
  assign swap = {b.exp, b.frac} > {a.exp, a.frac};
  assign big = swap ? b : a;
  assign sml = swap ? a : b;
  assign sub = big.sign ^ sml.sign;
  // subnormals sit on the exponent-1 grid with a zero hidden bit
  assign eb_eff = big.exp == '0 ? 8'd1 : big.exp;
  assign es_eff = sml.exp == '0 ? 8'd1 : sml.exp;
  assign d = eb_eff - es_eff;
  // {hidden, frac, guard, round, sticky}; large shifts fall entirely into sticky
  assign sml_ext = {sml.exp != '0, sml.frac, 3'b000};
  assign sml_sh = sml_ext >> d;
  assign lost = |(sml_ext & ~({27{1'b1}} << d));
  assign aligned = {sml_sh[26:1], sml_sh[0] | lost};
  assign big_ext = {1'b0, big.exp != '0, big.frac, 3'b000};
  assign raw = sub ? big_ext - {1'b0, aligned} : big_ext + {1'b0, aligned};
  fp_lzc24 u_lzc (.d(raw[26:3]), .cnt(lz));
  // left shift stops at exponent 1 so tiny results land as subnormals
  assign e = {1'b0, eb_eff};
  assign lim = e - 9'd1;
  assign sh = {4'b0, lz} > lim ? lim : {4'b0, lz};
  assign norm = raw[27] ? {raw[27:2], |raw[1:0]} : raw[26:0] << sh;
  assign en = raw[27] ? e + 9'd1 : e - sh;
  assign ef = norm[26] ? en : 9'd0;
  assign inexact = |norm[2:0];
  assign rup = norm[2] & (norm[1] | norm[0] | norm[3]);
  // rounding carry ripples from fraction into exponent, covering subnormal->normal too
  assign rnd = {ef, norm[25:3]} + {31'b0, rup};
  assign ovf = rnd[31:23] >= 9'd255;
  assign zero = raw == '0;
  always_comb begin
    n_sum = {big.sign, rnd[30:0]};
    n_ovf = 1'b0;
    n_unf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && sub)) n_sum = QNAN;
    else if (a_inf) n_sum = A;
    else if (b_inf) n_sum = B;
    else if (zero) n_sum = {a.sign & b.sign, 31'b0};
    else if (ovf) begin
      n_sum = {big.sign, POS_INF[30:0]};
      n_ovf = 1'b1;
    end else n_unf = rnd[30:23] == '0 && inexact;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Sum <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      Sum <= n_sum;
      overflow <= n_ovf;
      underflow <= n_unf;
    end
endmodule

// File: tb/tb_fp_adder.sv
// tb_fp_adder: scoreboard bench for fp_adder with directed vectors
module tb_fp_adder;
  logic clk = 1'b0, rst_n;
  logic [31:0] A, B, Sum;
  logic overflow, underflow;
  logic [33:0] exp_q[$];
  int id_q[$];
  int checks = 0, fails = 0;
  fp_adder dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .Sum(Sum), .overflow(overflow), .underflow(underflow));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got sum=%h ovf=%b unf=%b, want sum=%h ovf=%b unf=%b",
               name, got[33:2], got[1], got[0], want[33:2], want[1], want[0]);
    end
  endtask
  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic o, input logic u);
    @(negedge clk);
    A = a;
    B = b;
    exp_q.push_back({s, o, u});
    id_q.push_back(id);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) chk($sformatf("vec%0d", id_q.pop_front()), {Sum, overflow, underflow}, exp_q.pop_front());
  end
  initial begin
    rst_n = 1'b0;
    A = '0;
    B = '0;
    #1 chk("reset_init", {Sum, overflow, underflow}, 34'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    drive(0, 32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000, 0, 0);
    drive(1, 32'hBE80_0000, 32'hBE00_0000, 32'hBEC0_0000, 0, 0);
    drive(2, 32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000, 0, 0);
    drive(3, 32'hBE80_0000, 32'h3E00_0000, 32'hBE00_0000, 0, 0);
    drive(4, 32'hC093_3333, 32'h40B9_999A, 32'h3F99_999C, 0, 0);
    drive(5, 32'h7F5F_FFFE, 32'h7F5F_FFFF, 32'h7F80_0000, 1, 0);
    drive(6, 32'hFF5F_FFFE, 32'hFF5F_FFFF, 32'hFF80_0000, 1, 0);
    drive(7, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 0, 0);
    drive(8, 32'h0004_0001, 32'h0010_0001, 32'h0014_0002, 0, 0);
    drive(9, 32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000, 0, 0);
    drive(10, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 0, 0);
    drive(11, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 0, 0);
    drive(12, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0);
    drive(13, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 0, 0);
    drive(14, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 0, 0);
    drive(15, 32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 0, 0);
    drive(16, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("reset_async", {Sum, overflow, underflow}, 34'h0);
    @(negedge clk) rst_n = 1'b1;
    drive(17, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 0, 0);
    drive(18, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 0, 0);
    drive(19, 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
